// File: rtl/word_pkg.sv
// word_pkg: letter patterns, word table and FSM states shared by the
// HELLO word sequencer and the matching word detector.
package word_pkg;

    localparam logic [7:0] H_SEG     = 8'b10001001;
    localparam logic [7:0] E_SEG     = 8'b10000110;
    localparam logic [7:0] L_SEG     = 8'b11000111;
    localparam logic [7:0] O_SEG     = 8'b10100011;
    localparam logic [7:0] BLANK_SEG = 8'hFF;

    localparam int WORD_LEN = 5;

    localparam logic [7:0] WORD [WORD_LEN] =
        '{H_SEG, E_SEG, L_SEG, L_SEG, O_SEG};

    typedef logic [2:0] idx_t;

    localparam idx_t LAST_IDX = idx_t'(WORD_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        SPELL,
        DONE
    } seq_state_t;

    // Out-of-range indices fall back to a blank display.
    function automatic logic [7:0] letter_seg(input idx_t idx);
        logic [7:0] seg;
        seg = BLANK_SEG;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (idx == idx_t'(i)) seg = WORD[i];
        end
        return seg;
    endfunction

endpackage

// File: rtl/slot_timer.sv
// slot_timer: loadable down-counter with hold; tc is registered and
// high in the cycle where the count sits at zero after a live step.
module slot_timer #(
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic run,
    input  logic hold,
    output logic zero,
    output logic tc
);

    localparam int W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [W-1:0] RELOAD = W'(GAP_CYCLES - 1);

    logic [W-1:0] count;

    // Reload on a new slot, otherwise count down unless held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= RELOAD;
            tc    <= (RELOAD == '0);
        end else if (run && !hold && count != '0) begin
            count <= count - W'(1);
            tc    <= (count == W'(1));
        end else begin
            tc    <= 1'b0;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/word_sequencer.sv
// word_sequencer: spells H-E-L-L-O as 7-segment patterns, one letter per
// GAP_CYCLES slot. Optional repeat mode via WORD_SEQ_LOOP_EN (loop_en).
module word_sequencer
    import word_pkg::*;
#(
    parameter int GAP_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       hold,
`ifdef WORD_SEQ_LOOP_EN
    input  logic       loop_en,
`endif
    output logic [7:0] char2seg,
    output logic       letter_done_pulse,
    output logic       busy,
    output logic       word_done_pulse
);

    seq_state_t state;
    seq_state_t state_n;
    idx_t       idx;
    idx_t       idx_n;
    logic       load;
    logic       run;
    logic       done_n;
    logic       zero;
    logic       wrap;

`ifdef WORD_SEQ_LOOP_EN
    assign wrap = loop_en;
`else
    assign wrap = 1'b0;
`endif

    slot_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (load),
        .run    (run),
        .hold   (hold),
        .zero   (zero),
        .tc     (letter_done_pulse)
    );

    // State, index and the registered display/status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            idx             <= '0;
            char2seg        <= BLANK_SEG;
            busy            <= 1'b0;
            word_done_pulse <= 1'b0;
        end else begin
            state           <= state_n;
            idx             <= idx_n;
            char2seg        <= (state_n == SPELL) ? letter_seg(idx_n)
                                                  : BLANK_SEG;
            busy            <= (state_n == SPELL);
            word_done_pulse <= done_n;
        end
    end

    // Next state, letter index and timer control.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        load    = 1'b0;
        done_n  = 1'b0;
        run     = (state == SPELL) && !abort;
        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                idx_n   = '0;
                if (start && !abort) begin
                    state_n = SPELL;
                    load    = 1'b1;
                end
            end
            SPELL: begin
                if (abort) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else if (!hold && zero) begin
                    if (idx == LAST_IDX) begin
                        done_n = 1'b1;
                        idx_n  = '0;
                        if (wrap) begin
                            load = 1'b1;
                        end else begin
                            state_n = DONE;
                        end
                    end else begin
                        idx_n = idx + idx_t'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                idx_n   = '0;
            end
        endcase
    end

endmodule
